// File: rtl/spatz_insn_tracker.sv
// -----------------------------------------------------------------------------
// spatz_insn_tracker
//
// Instruction-ID allocator and completion tracker between the Spatz decoder
// and the controller dispatch path. Every decoded non-CON request receives
// the lowest free instruction ID, and the tracker remembers which execution
// unit owns it. VFU, VLSU and VSLDU responses retire IDs; VFU responses that
// carry a scalar result are staged in a one-entry write-back buffer toward
// the scalar register file. Illegal retirements raise a sticky error flag.
//
// Optional feature macro: SPATZ_TRACKER_EXC_EN
//   When defined, a VLSU response with exc=1 latches a sticky exception flag
//   and the first faulting ID, and new requests are refused while it is set.
//   When undefined, the exc bit is ignored and exc_o/exc_id_o are absent.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  decoded request handshake
//   req_ex_unit_i            target unit of the request
//   req_id_o                 ID assigned to the request
//   vfu_rsp_*                VFU completion (valid/ready/payload)
//   vlsu_rsp_*               VLSU completion (always accepted)
//   vsldu_rsp_*              VSLDU completion (always accepted)
//   wb_valid_o/wb_ready_i    scalar write-back handshake
//   wb_data_o, wb_rd_o       write-back value and destination register
//   busy_o                   per-ID in-flight bits
//   idle_o                   nothing in flight and write-back buffer empty
//   err_o                    sticky protocol error
//   exc_o, exc_id_o          sticky VLSU exception and its ID (optional)
// -----------------------------------------------------------------------------

package spatz_pkg;

  localparam int unsigned NrParallelInstructions = 4;
  localparam int unsigned ELEN                   = 32;
  localparam int unsigned GPRWidth               = 5;

  typedef logic [$clog2(NrParallelInstructions)-1:0] spatz_id_t;

  typedef enum logic [1:0] {
    CON = 2'd0,
    VFU = 2'd1,
    LSU = 2'd2,
    SLD = 2'd3
  } ex_unit_e;

  typedef struct packed {
    spatz_id_t             id;
    logic                  wb;
    logic [ELEN-1:0]       result;
    logic [GPRWidth-1:0]   rd;
  } vfu_rsp_t;

  typedef struct packed {
    spatz_id_t id;
    logic      exc;
  } vlsu_rsp_t;

  typedef struct packed {
    spatz_id_t id;
  } vsldu_rsp_t;

endpackage

module spatz_insn_tracker
  import spatz_pkg::*;
#(
  parameter int unsigned NrIds   = spatz_pkg::NrParallelInstructions,
  parameter int unsigned IdWidth = $clog2(NrIds)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  ex_unit_e            req_ex_unit_i,
  output logic [IdWidth-1:0]  req_id_o,
  input  logic                vfu_rsp_valid_i,
  output logic                vfu_rsp_ready_o,
  input  vfu_rsp_t            vfu_rsp_i,
  input  logic                vlsu_rsp_valid_i,
  input  vlsu_rsp_t           vlsu_rsp_i,
  input  logic                vsldu_rsp_valid_i,
  input  vsldu_rsp_t          vsldu_rsp_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [ELEN-1:0]     wb_data_o,
  output logic [GPRWidth-1:0] wb_rd_o,
  output logic [NrIds-1:0]    busy_o,
  output logic                idle_o,
  output logic                err_o
`ifdef SPATZ_TRACKER_EXC_EN
  ,
  output logic                exc_o,
  output logic [IdWidth-1:0]  exc_id_o
`endif
);

  // A retirement is illegal if the ID is not in flight or belongs to another unit.
  function automatic logic retire_bad(input logic busy, input ex_unit_e owner,
                                      input ex_unit_e unit);
    return !busy || (owner != unit);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NrIds-1:0]    busy_q, busy_d;
  ex_unit_e            unit_q [NrIds];
  ex_unit_e            unit_d [NrIds];
  logic                wb_full_q, wb_full_d;
  logic [ELEN-1:0]     wb_data_q, wb_data_d;
  logic [GPRWidth-1:0] wb_rd_q, wb_rd_d;
  logic                err_q, err_d;
  logic                exc_q;

`ifdef SPATZ_TRACKER_EXC_EN
  logic                exc_d;
  logic [IdWidth-1:0]  exc_id_q, exc_id_d;
  logic                exc_set_s;
`else
  logic                unused_exc_s;
  assign unused_exc_s = vlsu_rsp_i.exc;
  assign exc_q        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Allocation
  // ---------------------------------------------------------------------------
  logic [IdWidth-1:0] free_id_s;
  logic               any_free_s;
  logic               take_s;
  logic               alloc_s;
  logic [NrIds-1:0]   alloc_mask_s;

  // Lowest free ID and ready/ID outputs; depend only on registered state and the unit field.
  always_comb begin
    free_id_s  = '0;
    any_free_s = 1'b0;
    take_s     = 1'b0;
    for (int i = 0; i < NrIds; i++) begin
      take_s     = !busy_q[i] && !any_free_s;
      free_id_s  = take_s ? IdWidth'(i) : free_id_s;
      any_free_s = any_free_s | !busy_q[i];
    end
    if (req_ex_unit_i == CON) begin
      req_ready_o = !exc_q;
      req_id_o    = '0;
    end else begin
      req_ready_o = any_free_s && !exc_q;
      req_id_o    = free_id_s;
    end
  end

  assign alloc_s      = req_valid_i && req_ready_o && (req_ex_unit_i != CON);
  assign alloc_mask_s = alloc_s ? (NrIds'(1'b1) << req_id_o) : '0;

  // ---------------------------------------------------------------------------
  // Retirement and protocol checking
  // ---------------------------------------------------------------------------
  logic             vfu_hs_s;
  logic [NrIds-1:0] retire_mask_s;
  logic             err_set_s;
  logic             dup_s;

  assign vfu_rsp_ready_o = !wb_full_q || wb_ready_i;
  assign vfu_hs_s        = vfu_rsp_valid_i && vfu_rsp_ready_o;

  // Next busy/owner state and error detection; allocation never targets a busy ID,
  // so clearing retired bits before setting the allocated one is order-safe.
  always_comb begin
    retire_mask_s = (vfu_hs_s          ? (NrIds'(1'b1) << vfu_rsp_i.id)   : '0)
                  | (vlsu_rsp_valid_i  ? (NrIds'(1'b1) << vlsu_rsp_i.id)  : '0)
                  | (vsldu_rsp_valid_i ? (NrIds'(1'b1) << vsldu_rsp_i.id) : '0);
    busy_d = (busy_q & ~retire_mask_s) | alloc_mask_s;
    for (int i = 0; i < NrIds; i++) begin
      unit_d[i] = (alloc_s && (req_id_o == IdWidth'(i))) ? req_ex_unit_i : unit_q[i];
    end
    dup_s = (vfu_hs_s && vlsu_rsp_valid_i && (vfu_rsp_i.id == vlsu_rsp_i.id))
         || (vfu_hs_s && vsldu_rsp_valid_i && (vfu_rsp_i.id == vsldu_rsp_i.id))
         || (vlsu_rsp_valid_i && vsldu_rsp_valid_i && (vlsu_rsp_i.id == vsldu_rsp_i.id));
    err_set_s = dup_s
      || (vfu_hs_s && retire_bad(busy_q[vfu_rsp_i.id], unit_q[vfu_rsp_i.id], VFU))
      || (vlsu_rsp_valid_i && retire_bad(busy_q[vlsu_rsp_i.id], unit_q[vlsu_rsp_i.id], LSU))
      || (vsldu_rsp_valid_i && retire_bad(busy_q[vsldu_rsp_i.id], unit_q[vsldu_rsp_i.id], SLD));
    err_d = err_q || err_set_s;
  end

  // ---------------------------------------------------------------------------
  // Write-back buffer: a new load wins over a drain in the same cycle, which
  // gives one write-back per cycle while wb_ready_i stays high.
  // ---------------------------------------------------------------------------
  // Next write-back buffer contents.
  always_comb begin
    wb_full_d = wb_full_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    if (vfu_hs_s && vfu_rsp_i.wb) begin
      wb_full_d = 1'b1;
      wb_data_d = vfu_rsp_i.result;
      wb_rd_d   = vfu_rsp_i.rd;
    end else if (wb_ready_i) begin
      wb_full_d = 1'b0;
    end else begin
      wb_full_d = wb_full_q;
    end
  end

`ifdef SPATZ_TRACKER_EXC_EN
  // Only the first faulting VLSU response is recorded.
  always_comb begin
    exc_set_s = vlsu_rsp_valid_i && vlsu_rsp_i.exc && !exc_q;
    exc_d     = exc_q || exc_set_s;
    if (exc_set_s) begin
      exc_id_d = IdWidth'(vlsu_rsp_i.id);
    end else begin
      exc_id_d = exc_id_q;
    end
  end

  // Exception state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exc_q    <= 1'b0;
      exc_id_q <= '0;
    end else begin
      exc_q    <= exc_d;
      exc_id_q <= exc_id_d;
    end
  end

  assign exc_o    = exc_q;
  assign exc_id_o = exc_id_q;
`endif

  // Tracker state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= '0;
      unit_q    <= '{default: CON};
      wb_full_q <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      unit_q    <= unit_d;
      wb_full_q <= wb_full_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      err_q     <= err_d;
    end
  end

  assign busy_o     = busy_q;
  assign idle_o     = ~|busy_q && !wb_full_q;
  assign wb_valid_o = wb_full_q;
  assign wb_data_o  = wb_data_q;
  assign wb_rd_o    = wb_rd_q;
  assign err_o      = err_q;

endmodule
